// File: rtl/stage2_decode.sv
// RV32I decode stage: register file with write-through, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module stage2_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ifidINST,
  input  logic [31:0] ifidPc,
  input  logic        flush,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbRd,
  input  logic [31:0] wbData,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic [31:0] idexPc,
  output logic [31:0] idexRs1Data,
  output logic [31:0] idexRs2Data,
  output logic [31:0] idexImm,
  output logic [4:0]  idexRs1,
  output logic [4:0]  idexRs2,
  output logic [4:0]  idexRd,
  output logic [2:0]  idexFunct3,
  output logic [3:0]  idexAluCtrl,
  output logic        idexAluSrc,
  output logic        idexPcSrcA,
  output logic        idexMemRead,
  output logic        idexMemWrite,
  output logic        idexRegWrite,
  output logic        idexMemToReg,
  output logic        idexBranch,
  output logic        idexJump
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        pc_src_a;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } idex_t;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic        rs1_used, rs2_used, valid, hazard;
  logic [3:0]  alu_r, alu_i;
  idex_t       dec, idex_d, idex_q;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  assign opcode    = ifidINST[6:0];
  assign rd        = ifidINST[11:7];
  assign funct3    = ifidINST[14:12];
  assign rs1       = ifidINST[19:15];
  assign rs2       = ifidINST[24:20];
  assign funct7_b5 = ifidINST[30];

  assign imm_i = {{20{ifidINST[31]}}, ifidINST[31:20]};
  assign imm_s = {{20{ifidINST[31]}}, ifidINST[31:25], ifidINST[11:7]};
  assign imm_b = {{19{ifidINST[31]}}, ifidINST[31], ifidINST[7], ifidINST[30:25],
                  ifidINST[11:8], 1'b0};
  assign imm_u = {ifidINST[31:12], 12'b0};
  assign imm_j = {{11{ifidINST[31]}}, ifidINST[31], ifidINST[19:12], ifidINST[20],
                  ifidINST[30:21], 1'b0};

  // Register file; x0 is never written and always reads as zero.
  assign wb_en = wbRegWrite && (wbRd != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wbRd] = wbData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    if (rs1 == 5'd0)                 rs1_data = '0;
    else if (wb_en && (wbRd == rs1)) rs1_data = wbData;
    else                             rs1_data = rf_q[rs1];
    if (rs2 == 5'd0)                 rs2_data = '0;
    else if (wb_en && (wbRd == rs2)) rs2_data = wbData;
    else                             rs2_data = rf_q[rs2];
  end

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt_add,
                                            input logic alt_shift);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt_add ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt_shift ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // OP-IMM never subtracts; only the shift-right form honours funct7[5].
  assign alu_r = alu_decode(funct3, funct7_b5, funct7_b5);
  assign alu_i = alu_decode(funct3, 1'b0, funct7_b5);

  always_comb begin
    dec          = '0;
    dec.pc       = ifidPc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.funct3   = funct3;
    valid        = 1'b1;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    unique case (opcode)
      OpReg: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_r;
        rs2_used      = 1'b1;
      end
      OpImm: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_i;
        dec.imm       = imm_i;
      end
      OpLoad: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_ctrl   = AluAdd;
        dec.imm        = imm_i;
      end
      OpStore: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctrl  = AluAdd;
        dec.imm       = imm_s;
        rs2_used      = 1'b1;
      end
      OpBranch: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = AluSub;
        dec.imm      = imm_b;
        rs2_used     = 1'b1;
      end
      OpJal: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.pc_src_a  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluAdd;
        dec.imm       = imm_j;
        rs1_used      = 1'b0;
      end
      OpJalr: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluAdd;
        dec.imm       = imm_i;
      end
      OpLui: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = AluPassB;
        dec.imm       = imm_u;
        rs1_used      = 1'b0;
      end
      OpAuipc: begin
        dec.pc_src_a  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = AluAdd;
        dec.imm       = imm_u;
        rs1_used      = 1'b0;
      end
      default: valid = 1'b0;
    endcase
  end

  assign hazard = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  (((idex_q.rd == rs1) && rs1_used) || ((idex_q.rd == rs2) && rs2_used));

  assign pcWrite   = ~hazard;
  assign ifidWrite = hazard;

  always_comb begin
    idex_d = dec;
    if (!valid || flush || hazard) begin
      idex_d.rd         = '0;
      idex_d.alu_ctrl   = '0;
      idex_d.alu_src    = 1'b0;
      idex_d.pc_src_a   = 1'b0;
      idex_d.mem_read   = 1'b0;
      idex_d.mem_write  = 1'b0;
      idex_d.reg_write  = 1'b0;
      idex_d.mem_to_reg = 1'b0;
      idex_d.branch     = 1'b0;
      idex_d.jump       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign idexPc       = idex_q.pc;
  assign idexRs1Data  = idex_q.rs1_data;
  assign idexRs2Data  = idex_q.rs2_data;
  assign idexImm      = idex_q.imm;
  assign idexRs1      = idex_q.rs1;
  assign idexRs2      = idex_q.rs2;
  assign idexRd       = idex_q.rd;
  assign idexFunct3   = idex_q.funct3;
  assign idexAluCtrl  = idex_q.alu_ctrl;
  assign idexAluSrc   = idex_q.alu_src;
  assign idexPcSrcA   = idex_q.pc_src_a;
  assign idexMemRead  = idex_q.mem_read;
  assign idexMemWrite = idex_q.mem_write;
  assign idexRegWrite = idex_q.reg_write;
  assign idexMemToReg = idex_q.mem_to_reg;
  assign idexBranch   = idex_q.branch;
  assign idexJump     = idex_q.jump;

endmodule

// File: tb/tb_stage2_decode.sv
// Scoreboard bench for stage2_decode: expected ID/EX contents are queued when an
// instruction is presented and compared one edge later under a don't-care mask.
module tb_stage2_decode;

  logic        clk, reset, flush, wbRegWrite;
  logic [31:0] ifidINST, ifidPc, wbData;
  logic [4:0]  wbRd;
  logic        pcWrite, ifidWrite;
  logic [31:0] idexPc, idexRs1Data, idexRs2Data, idexImm;
  logic [4:0]  idexRs1, idexRs2, idexRd;
  logic [2:0]  idexFunct3;
  logic [3:0]  idexAluCtrl;
  logic        idexAluSrc, idexPcSrcA, idexMemRead, idexMemWrite;
  logic        idexRegWrite, idexMemToReg, idexBranch, idexJump;

  stage2_decode dut (
    .clk(clk), .reset(reset), .ifidINST(ifidINST), .ifidPc(ifidPc), .flush(flush),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .idexPc(idexPc), .idexRs1Data(idexRs1Data), .idexRs2Data(idexRs2Data),
    .idexImm(idexImm), .idexRs1(idexRs1), .idexRs2(idexRs2), .idexRd(idexRd),
    .idexFunct3(idexFunct3), .idexAluCtrl(idexAluCtrl), .idexAluSrc(idexAluSrc),
    .idexPcSrcA(idexPcSrcA), .idexMemRead(idexMemRead), .idexMemWrite(idexMemWrite),
    .idexRegWrite(idexRegWrite), .idexMemToReg(idexMemToReg), .idexBranch(idexBranch),
    .idexJump(idexJump)
  );

  // ctrl order: {AluSrc, PcSrcA, MemRead, MemWrite, RegWrite, MemToReg, Branch, Jump}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [7:0]  ctrl;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
    obs_t  mask;
  } sb_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  alu;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    bit          imm_care;
  } tbl_t;

  localparam logic [7:0] CtlR    = 8'b0000_1000;
  localparam logic [7:0] CtlI    = 8'b1000_1000;
  localparam logic [7:0] CtlLd   = 8'b1010_1100;
  localparam logic [7:0] CtlSt   = 8'b1001_0000;
  localparam logic [7:0] CtlBr   = 8'b0000_0010;
  localparam logic [7:0] CtlJal  = 8'b1100_1001;
  localparam logic [7:0] CtlJalr = 8'b1000_1001;
  localparam logic [7:0] CtlAui  = 8'b1100_1000;

  obs_t        obs;
  sb_t         sb_q[$];
  sb_t         e;
  logic [31:0] ref_rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  assign obs = {idexPc, idexRs1Data, idexRs2Data, idexImm, idexRs1, idexRs2, idexRd,
                idexFunct3, idexAluCtrl, idexAluSrc, idexPcSrcA, idexMemRead, idexMemWrite,
                idexRegWrite, idexMemToReg, idexBranch, idexJump};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ref_rf[i] <= '0;
    end else if (wbRegWrite && wbRd != 5'd0) begin
      ref_rf[wbRd] <= wbData;
    end
  end

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (wbRegWrite && wbRd == idx) return wbData;
    return ref_rf[idx];
  endfunction

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wbRegWrite = en;
    wbRd       = rd;
    wbData     = data;
  endtask

  task automatic issue(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [3:0] alu, input logic [7:0] ctrl, input logic [31:0] imm,
                       input bit imm_care, input bit bubble);
    obs_t x, m;
    ifidINST = inst;
    ifidPc   = pc;
    x.pc   = pc;
    x.rs1d = ref_read(inst[19:15]);
    x.rs2d = ref_read(inst[24:20]);
    x.imm  = imm;
    x.rs1  = inst[19:15];
    x.rs2  = inst[24:20];
    x.rd   = inst[11:7];
    x.f3   = inst[14:12];
    x.alu  = alu;
    x.ctrl = ctrl;
    m = '1;
    if (!imm_care) m.imm = '0;
    if (!ctrl[3])  m.rd  = '0;
    if (bubble) begin
      x = '0;
      m = '0;
      m.ctrl = '1;
      m.rd   = '1;
    end
    sb_q.push_back('{nm, x, m});
  endtask

  task automatic test_reset();
    set_wb(1'b1, 5'd5, 32'h0000_0055);
    issue("pre_reset_add", 32'h0001_8233, 32'h10, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    set_wb(1'b0, 5'd0, 32'h0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_errors++; $display("FAIL reset_idex: got %h want 0", obs);
    end
    n_checks++;
    if (pcWrite !== 1'b1 || ifidWrite !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall: got pcWrite=%b ifidWrite=%b want 1/0",
                           pcWrite, ifidWrite);
    end
    #1 reset = 1'b0;
    issue("reset_reads_x5", 32'h0002_8333, 32'h14, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
  endtask

  task automatic test_write_through();
    set_wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    issue("write_through", 32'h0001_8233, 32'h20, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    n_checks++;
    if (idexRs1Data !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL wt_rs1data: got %h want deadbeef", idexRs1Data);
    end
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_x0();
    set_wb(1'b1, 5'd0, 32'h0000_1234);
    issue("x0_same_cycle", 32'h0000_0233, 32'h28, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    set_wb(1'b0, 5'd0, 32'h0);
    issue("x0_later", 32'h0000_0233, 32'h2C, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
  endtask

  task automatic test_imm();
    issue("beq_m8", 32'hFE00_0CE3, 32'h30, 4'd1, CtlBr, 32'hFFFF_FFF8, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    issue("lui", 32'hABCD_E0B7, 32'h34, 4'd10, CtlI, 32'hABCD_E000, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
  endtask

  task automatic test_load_use();
    set_wb(1'b1, 5'd1, 32'h0000_0100);
    issue("lw_x5", 32'h0000_A283, 32'h40, 4'd0, CtlLd, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    set_wb(1'b1, 5'd2, 32'h0000_0022);
    issue("lu_bubble", 32'h0022_8333, 32'h44, 4'd0, CtlR, 32'h0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (pcWrite !== 1'b0 || ifidWrite !== 1'b1) begin
      n_errors++; $display("FAIL lu_stall: got pcWrite=%b ifidWrite=%b want 0/1",
                           pcWrite, ifidWrite);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    set_wb(1'b0, 5'd0, 32'h0);
    n_checks++;
    if (pcWrite !== 1'b1 || ifidWrite !== 1'b0) begin
      n_errors++; $display("FAIL lu_release: got pcWrite=%b ifidWrite=%b want 1/0",
                           pcWrite, ifidWrite);
    end
    issue("lu_add", 32'h0022_8333, 32'h44, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    issue("lw_x0", 32'h0000_2003, 32'h48, 4'd0, CtlLd, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    issue("x0_dep_add", 32'h0020_0333, 32'h4C, 4'd0, CtlR, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pcWrite !== 1'b1 || ifidWrite !== 1'b0) begin
      n_errors++; $display("FAIL x0_no_stall: got pcWrite=%b ifidWrite=%b want 1/0",
                           pcWrite, ifidWrite);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    issue("flush_sw", 32'h0020_A223, 32'h50, 4'd0, CtlSt, 32'h4, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    flush = 1'b0;
    issue("sw", 32'h0020_A223, 32'h54, 4'd0, CtlSt, 32'h4, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    issue("illegal_op", 32'h0000_007F, 32'h58, 4'd0, 8'h00, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    issue("lw_x5_b", 32'h0000_A283, 32'h60, 4'd0, CtlLd, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    flush = 1'b1;
    issue("flush_and_hazard", 32'h0022_8333, 32'h64, 4'd0, CtlR, 32'h0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (pcWrite !== 1'b0 || ifidWrite !== 1'b1) begin
      n_errors++; $display("FAIL fh_stall: got pcWrite=%b ifidWrite=%b want 0/1",
                           pcWrite, ifidWrite);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front(); n_checks++;
    if ((obs & e.mask) !== (e.exp & e.mask)) begin
      n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    tbl_t tbl[12];
    tbl[0]  = '{32'h4041_8433, 4'd1, CtlR,    32'h0,         1'b0}; // sub
    tbl[1]  = '{32'h4041_D493, 4'd7, CtlI,    32'h0000_0404, 1'b1}; // srai
    tbl[2]  = '{32'h4000_0613, 4'd0, CtlI,    32'h0000_0400, 1'b1}; // addi, imm bit 10
    tbl[3]  = '{32'h4001_C593, 4'd5, CtlI,    32'h0000_0400, 1'b1}; // xori
    tbl[4]  = '{32'hFFF0_0513, 4'd0, CtlI,    32'hFFFF_FFFF, 1'b1}; // addi -1
    tbl[5]  = '{32'hFFDF_F0EF, 4'd0, CtlJal,  32'hFFFF_FFFC, 1'b1}; // jal -4
    tbl[6]  = '{32'h1234_5697, 4'd0, CtlAui,  32'h1234_5000, 1'b1}; // auipc
    tbl[7]  = '{32'h0000_8067, 4'd0, CtlJalr, 32'h0,         1'b1}; // jalr
    tbl[8]  = '{32'h0041_A733, 4'd3, CtlR,    32'h0,         1'b0}; // slt
    tbl[9]  = '{32'h4041_D7B3, 4'd7, CtlR,    32'h0,         1'b0}; // sra
    tbl[10] = '{32'h0041_D7B3, 4'd6, CtlR,    32'h0,         1'b0}; // srl
    tbl[11] = '{32'hFE41_AE23, 4'd0, CtlSt,   32'hFFFF_FFFC, 1'b1}; // sw -4
    for (int i = 0; i < 12; i++) begin
      set_wb(1'b1, (i % 2 == 1) ? 5'd4 : 5'd3, 32'hA500_0000 + i);
      issue($sformatf("b2b_%0d", i), tbl[i].inst, 32'h100 + 4 * i, tbl[i].alu, tbl[i].ctrl,
            tbl[i].imm, tbl[i].imm_care, 1'b0);
      @(posedge clk); #1;
      e = sb_q.pop_front(); n_checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        n_errors++; $display("FAIL %s: got %h want %h mask %h", e.name, obs, e.exp, e.mask);
      end
    end
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    ifidINST = 32'h0;
    ifidPc   = 32'h0;
    set_wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_write_through();
    test_x0();
    test_imm();
    test_load_use();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
